axi4_lite_master_arbiter: RTL

Round-robin arbiter + sequencer; MASTERS simple requesters share one AXI4-Lite manager port, one transaction in flight.

---
 rtl/axi4_lite_master_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin arbiter and sequencer: several simple requesters share one AXI4-Lite manager port,
// with at most one transaction in flight at a time.
module axi4_lite_master_arbiter #(
    parameter int unsigned MASTERS    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned STRB      = DATA_WIDTH / 8,
    localparam int unsigned CW        = 1 + 3 + ADDR_WIDTH + DATA_WIDTH + STRB
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [MASTERS-1:0]      req_valid,
    output logic [MASTERS-1:0]      req_ready,
    input  logic [MASTERS*CW-1:0]   req_cmd,
    output logic [MASTERS-1:0]      rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [STRB-1:0]         m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp
);

    localparam int unsigned IDXW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    // Field offsets inside one command word {write, prot, addr, wdata, wstrb}
    localparam int unsigned WdataLsb = STRB;
    localparam int unsigned AddrLsb  = STRB + DATA_WIDTH;
    localparam int unsigned ProtLsb  = STRB + DATA_WIDTH + ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StWrAwW,
        StWrB,
        StRdAr,
        StRdR,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [IDXW-1:0]         ptr_q, ptr_d;
    logic [IDXW-1:0]         gnt_q, gnt_d;
    logic [CW-1:0]           cmd_q, cmd_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    logic [CW-1:0]           cmd_arr [MASTERS];
    logic [IDXW-1:0]         pick;
    logic                    pick_found;
    int unsigned             cand;

    for (genvar i = 0; i < MASTERS; i++) begin : g_unpack
        assign cmd_arr[i] = req_cmd[i*CW +: CW];
    end

    // First pending requester at or above the pointer, wrapping to 0.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= MASTERS) begin
                cand = cand - MASTERS;
            end
            if (!pick_found && req_valid[IDXW'(cand)]) begin
                pick       = IDXW'(cand);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cmd_d     = cmd_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        req_ready = '0;
        rsp_valid = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    req_ready[pick] = 1'b1;
                    gnt_d           = pick;
                    cmd_d           = cmd_arr[pick];
                    ptr_d           = (pick == IDXW'(MASTERS - 1)) ? '0 : pick + 1'b1;
                    aw_done_d       = 1'b0;
                    w_done_d        = 1'b0;
                    rdata_d         = '0;
                    resp_d          = '0;
                    state_d         = cmd_arr[pick][CW-1] ? StWrAwW : StRdAr;
                end
            end
            StWrAwW: begin
                // AW and W complete independently; move on once both have handshaked.
                if (m_awready) begin
                    aw_done_d = 1'b1;
                end
                if (m_wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = StWrB;
                end
            end
            StWrB: begin
                if (m_bvalid) begin
                    resp_d  = m_bresp;
                    state_d = StResp;
                end
            end
            StRdAr: begin
                if (m_arready) begin
                    state_d = StRdR;
                end
            end
            StRdR: begin
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    resp_d  = m_rresp;
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid[gnt_q] = 1'b1;
                state_d          = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_q     <= '0;
            cmd_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cmd_q     <= cmd_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // Payloads come straight from the captured command, so they are stable while valid.
    always_comb begin
        m_awvalid = (state_q == StWrAwW) && !aw_done_q;
        m_wvalid  = (state_q == StWrAwW) && !w_done_q;
        m_bready  = (state_q == StWrB);
        m_arvalid = (state_q == StRdAr);
        m_rready  = (state_q == StRdR);
        m_awaddr  = cmd_q[AddrLsb +: ADDR_WIDTH];
        m_araddr  = cmd_q[AddrLsb +: ADDR_WIDTH];
        m_awprot  = cmd_q[ProtLsb +: 3];
        m_arprot  = cmd_q[ProtLsb +: 3];
        m_wdata   = cmd_q[WdataLsb +: DATA_WIDTH];
        m_wstrb   = cmd_q[STRB-1:0];
        rsp_rdata = rdata_q;
        rsp_resp  = resp_q;
    end

endmodule
